// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite attribute (OAM) DMA engine.
//
// A CPU write to the DMA source register (DMA_REG_ADDR) copies DMA_LENGTH
// bytes from {source_high, 8'h00} to OAM_BASE. The engine uses three bus
// cycles per byte:
//   READ  : drive the source address
//   LATCH : hold the source address and capture the returned byte
//   WRITE : write the captured byte into OAM
// While the engine is idle, the CPU bus passes straight through to the MMU.
//
// Optional feature, selected by the macro OAM_DMA_START_DELAY_EN:
//   When defined, a register write first spends one DELAY cycle (passthrough
//   still active, not busy) before the first READ.
//
// Ports
//   iClock    : single clock; all state changes on its rising edge
//   iReset    : synchronous, active-high reset
//   iCpuAddr  : CPU bus address
//   iCpuWe    : CPU write strobe
//   iCpuData  : CPU write data
//   iMemData  : MMU read data for oAddr
//   oAddr     : address driven to the MMU
//   oWe       : write strobe driven to the MMU
//   oData     : write data driven to the MMU
//   oDMA      : DMA register value (MMU read-back)
//   oBusy     : DMA owns the bus; the CPU stalls while high
//   oDone     : one-cycle pulse on the final OAM write
// -----------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          DMA_LENGTH   = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  input  logic [7:0]  iMemData,
  output logic [15:0] oAddr,
  output logic        oWe,
  output logic [7:0]  oData,
  output logic [7:0]  oDMA,
  output logic        oBusy,
  output logic        oDone
);

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef OAM_DMA_START_DELAY_EN
    DELAY,
`endif
    READ,
    LATCH,
    WRITE
  } state_t;

`ifdef OAM_DMA_START_DELAY_EN
  localparam state_t START_STATE = DELAY;
`else
  localparam state_t START_STATE = READ;
`endif

  state_t      state;
  state_t      state_next;
  logic [7:0]  index;
  logic [7:0]  hold;
  logic [7:0]  dma_reg;

  logic        dma_wr;
  logic [7:0]  src_high;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic        last_byte;

  // A register write restarts the engine from any state.
  assign dma_wr    = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

  // Echo RAM (E000..FFFF) folds back onto work RAM; oDMA keeps the raw value.
  assign src_high  = (dma_reg < 8'hE0) ? dma_reg : (dma_reg - 8'h20);
  assign src_addr  = {src_high, index};
  assign dst_addr  = OAM_BASE + {8'h00, index};
  assign last_byte = (index == LAST_INDEX);

  assign oDMA      = dma_reg;

  // NOTE: every output of this block is given a default first so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    oAddr      = iCpuAddr;
    oWe        = iCpuWe;
    oData      = iCpuData;
    oBusy      = 1'b0;
    oDone      = 1'b0;

    case (state)
      IDLE: begin
        if (dma_wr) state_next = START_STATE;
      end
`ifdef OAM_DMA_START_DELAY_EN
      DELAY: begin
        state_next = dma_wr ? DELAY : READ;
      end
`endif
      READ: begin
        oAddr      = src_addr;
        oWe        = 1'b0;
        oData      = hold;
        oBusy      = 1'b1;
        state_next = dma_wr ? START_STATE : LATCH;
      end
      LATCH: begin
        oAddr      = src_addr;
        oWe        = 1'b0;
        oData      = hold;
        oBusy      = 1'b1;
        state_next = dma_wr ? START_STATE : WRITE;
      end
      WRITE: begin
        oAddr = dst_addr;
        oWe   = 1'b1;
        oData = hold;
        oBusy = 1'b1;
        if (dma_wr) begin
          // A restart on the final write aborts the transfer: no completion.
          state_next = START_STATE;
        end else if (last_byte) begin
          state_next = IDLE;
          oDone      = 1'b1;
        end else begin
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= IDLE;
      index   <= 8'h00;
      hold    <= 8'h00;
      dma_reg <= 8'h00;
    end else begin
      state <= state_next;

      if (dma_wr) begin
        dma_reg <= iCpuData;
        index   <= 8'h00;
      end else if ((state == WRITE) && !last_byte) begin
        index <= index + 8'h01;
      end

      if (state == LATCH) hold <= iMemData;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma -- directed self-checking bench for oam_dma.
// A simple MMU model (64 KiB byte array) answers reads combinationally and
// commits writes on the rising edge. A negedge monitor accumulates bus
// statistics that the scenario tasks compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_oam_dma;

`ifdef OAM_DMA_START_DELAY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  iMemData;
  logic [15:0] oAddr;
  logic        oWe;
  logic [7:0]  oData;
  logic [7:0]  oDMA;
  logic        oBusy;
  logic        oDone;

  int checks   = 0;
  int failures = 0;

  oam_dma dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iCpuAddr (iCpuAddr),
    .iCpuWe   (iCpuWe),
    .iCpuData (iCpuData),
    .iMemData (iMemData),
    .oAddr    (oAddr),
    .oWe      (oWe),
    .oData    (oData),
    .oDMA     (oDMA),
    .oBusy    (oBusy),
    .oDone    (oDone)
  );

  always #5 iClock = ~iClock;

  // MMU model
  logic [7:0] mem [0:65535];
  assign iMemData = mem[oAddr];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + i] = 8'(i) ^ 8'hA5;
      mem[16'hD000 + i] = 8'(i) ^ 8'h33;
    end
    mem[16'h8000] = 8'h11;
    forever begin
      @(posedge iClock);
      if (oWe) mem[oAddr] <= oData;
    end
  end

  // Cycle counter and bus monitor (single writer for every statistic)
  int   cyc = 0;
  always @(posedge iClock) cyc <= cyc + 1;

  int   busy_cnt = 0, done_cnt = 0, stray = 0;
  int   rise_cyc = 0, last_busy_cyc = 0, done_cyc = 0, last_wr_idx = -1;
  logic prev_busy = 1'b0;
  logic [15:0] first_addr = 16'h0000;

  always @(negedge iClock) begin
    if (oBusy) begin
      busy_cnt++;
      last_busy_cyc = cyc;
      if (!prev_busy) begin
        rise_cyc   = cyc;
        first_addr = oAddr;
      end
      if (oWe) begin
        if (oAddr >= 16'hFE00 && oAddr < 16'hFEA0) last_wr_idx = int'(oAddr - 16'hFE00);
        else stray++;
      end
    end
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_busy = oBusy;
  end

  int t_start;

  // Call just after a negedge; returns one negedge later (cycle T+1).
  task automatic cpu_dma_write(input logic [7:0] val);
    t_start  = cyc;
    iCpuAddr = 16'hFF46;
    iCpuWe   = 1'b1;
    iCpuData = val;
    @(negedge iClock);
    iCpuWe   = 1'b0;
    iCpuAddr = 16'h0000;
    iCpuData = 8'h00;
  endtask

  task automatic check_oam(input string name, input logic [7:0] key);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + i] !== (8'(i) ^ key)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d OAM bytes differ, required 0", name, bad);
    end
  endtask

  task automatic test_reset;
    iReset   = 1'b1;
    iCpuAddr = 16'h1234;
    iCpuWe   = 1'b0;
    iCpuData = 8'h5A;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    @(negedge iClock);
    checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", oBusy); end
    checks++; if (oDone !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b required 0", oDone); end
    checks++; if (oDMA !== 8'h00) begin failures++; $display("FAIL reset_dma: got %h required 00", oDMA); end
    checks++; if (oAddr !== 16'h1234) begin failures++; $display("FAIL reset_addr: got %h required 1234", oAddr); end
  endtask

  task automatic test_passthrough;
    iCpuAddr = 16'h2345; iCpuWe = 1'b1; iCpuData = 8'hC3;
    #1;
    checks++; if ({oAddr, oWe, oData} !== {16'h2345, 1'b1, 8'hC3}) begin
      failures++; $display("FAIL passthrough_wr: got %h/%b/%h required 2345/1/c3", oAddr, oWe, oData); end
    iCpuAddr = 16'h9876; iCpuWe = 1'b0; iCpuData = 8'h01;
    #1;
    checks++; if ({oAddr, oWe, oData} !== {16'h9876, 1'b0, 8'h01}) begin
      failures++; $display("FAIL passthrough_rd: got %h/%b/%h required 9876/0/01", oAddr, oWe, oData); end
    @(negedge iClock);
    iCpuAddr = 16'h0000;
  endtask

  task automatic test_basic;
    int b_busy = busy_cnt, b_done = done_cnt, b_stray = stray;
    cpu_dma_write(8'hC0);
    repeat (499) @(negedge iClock);
    checks++; if (busy_cnt - b_busy != 480) begin failures++; $display("FAIL basic_busy_cycles: got %0d required 480", busy_cnt - b_busy); end
    checks++; if (rise_cyc - t_start != 1 + D) begin failures++; $display("FAIL basic_busy_rise: got T+%0d required T+%0d", rise_cyc - t_start, 1 + D); end
    checks++; if (last_busy_cyc - t_start != 480 + D) begin failures++; $display("FAIL basic_busy_last: got T+%0d required T+%0d", last_busy_cyc - t_start, 480 + D); end
    checks++; if (done_cnt - b_done != 1) begin failures++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - b_done); end
    checks++; if (done_cyc - t_start != 480 + D) begin failures++; $display("FAIL basic_done_cycle: got T+%0d required T+%0d", done_cyc - t_start, 480 + D); end
    checks++; if (first_addr !== 16'hC000) begin failures++; $display("FAIL basic_first_addr: got %h required c000", first_addr); end
    checks++; if (stray != b_stray) begin failures++; $display("FAIL basic_stray_writes: got %0d required 0", stray - b_stray); end
    checks++; if (oDMA !== 8'hC0) begin failures++; $display("FAIL basic_dma_reg: got %h required c0", oDMA); end
    check_oam("basic_oam", 8'h5A);
  endtask

  task automatic test_cpu_block;
    int b_stray = stray;
    cpu_dma_write(8'hE1);
    repeat (10) @(negedge iClock);
    iCpuAddr = 16'h8000; iCpuWe = 1'b1; iCpuData = 8'hAA;
    repeat (5) @(negedge iClock);
    iCpuWe = 1'b0; iCpuAddr = 16'h0000; iCpuData = 8'h00;
    repeat (490) @(negedge iClock);
    checks++; if (mem[16'h8000] !== 8'h11) begin failures++; $display("FAIL block_cpu_write: mem[8000] got %h required 11", mem[16'h8000]); end
    checks++; if (stray != b_stray) begin failures++; $display("FAIL block_stray_writes: got %0d required 0", stray - b_stray); end
    checks++; if (first_addr !== 16'hC100) begin failures++; $display("FAIL echo_first_addr: got %h required c100", first_addr); end
    checks++; if (oDMA !== 8'hE1) begin failures++; $display("FAIL echo_dma_reg: got %h required e1", oDMA); end
    check_oam("echo_oam", 8'hA5);
  endtask

  task automatic test_restart;
    int b_done = done_cnt, t_restart;
    cpu_dma_write(8'hC0);
    repeat (150 + D) @(negedge iClock);  // now in the READ cycle of index 50
    t_restart = cyc;
    iCpuAddr = 16'hFF46; iCpuWe = 1'b1; iCpuData = 8'hD0;
    @(negedge iClock);
    iCpuWe = 1'b0; iCpuAddr = 16'h0000; iCpuData = 8'h00;
    repeat (500) @(negedge iClock);
    checks++; if (done_cnt - b_done != 1) begin failures++; $display("FAIL restart_done_count: got %0d required 1", done_cnt - b_done); end
    checks++; if (done_cyc - t_restart != 480 + D) begin failures++; $display("FAIL restart_done_cycle: got T+%0d required T+%0d", done_cyc - t_restart, 480 + D); end
    checks++; if (oDMA !== 8'hD0) begin failures++; $display("FAIL restart_dma_reg: got %h required d0", oDMA); end
    checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL restart_idle: got %0b required 0", oBusy); end
    check_oam("restart_oam", 8'h33);
  endtask

  task automatic test_reset_mid;
    int b_busy = busy_cnt, b_done = done_cnt;
    cpu_dma_write(8'hC0);
    repeat (240 + D) @(negedge iClock);  // now in the READ cycle of index 80
    iReset = 1'b1;
    iCpuAddr = 16'h4321;
    @(negedge iClock);
    iReset = 1'b0;
    checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %0b required 0", oBusy); end
    checks++; if (oAddr !== 16'h4321) begin failures++; $display("FAIL midreset_passthrough: got %h required 4321", oAddr); end
    checks++; if (oDMA !== 8'h00) begin failures++; $display("FAIL midreset_dma_reg: got %h required 00", oDMA); end
    repeat (500) @(negedge iClock);
    checks++; if (busy_cnt - b_busy != 241) begin failures++; $display("FAIL midreset_busy_cycles: got %0d required 241", busy_cnt - b_busy); end
    checks++; if (last_wr_idx != 79) begin failures++; $display("FAIL midreset_last_index: got %0d required 79", last_wr_idx); end
    checks++; if (done_cnt != b_done) begin failures++; $display("FAIL midreset_done: got %0d pulses required 0", done_cnt - b_done); end
    checks++; if (mem[16'hFE4F] !== (8'h4F ^ 8'h5A)) begin failures++; $display("FAIL midreset_fe4f: got %h required %h", mem[16'hFE4F], 8'h4F ^ 8'h5A); end
    checks++; if (mem[16'hFE50] !== (8'h50 ^ 8'h33)) begin failures++; $display("FAIL midreset_fe50: got %h required %h", mem[16'hFE50], 8'h50 ^ 8'h33); end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_basic;
    test_cpu_block;
    test_restart;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter OAM_BASE, default 16'hFE00: destination base address of the OAM copy.
REQ-002 Parameter DMA_LENGTH, default 160: bytes per transfer.
REQ-003 Parameter DMA_REG_ADDR, default 16'hFF46: address of the DMA source register.
REQ-004 iClock  input  1  single clock; all state changes on its rising edge.
REQ-005 iReset  input  1  synchronous, active-high reset.
REQ-006 iCpuAddr  input  16  CPU bus address.
REQ-007 iCpuWe  input  1  CPU write strobe.
REQ-008 iCpuData  input  8  CPU write data.
REQ-009 iMemData  input  8  read data returned by the MMU for oAddr.
REQ-010 oAddr  output  16  address driven to the MMU.
REQ-011 oWe  output  1  write strobe driven to the MMU.
REQ-012 oData  output  8  write data driven to the MMU.
REQ-013 oDMA  output  8  DMA register value, fed to the MMU iGPU_DMA read-back input.
REQ-014 oBusy  output  1  DMA owns the bus; the CPU stalls while high.
REQ-015 oDone  output  1  one-cycle pulse on the final OAM write.

Function
REQ-016 The FSM SHALL have states IDLE, DELAY (only with the configuration macro), READ, LATCH and WRITE.
REQ-017 In IDLE the block SHALL pass through combinationally: oAddr=iCpuAddr, oWe=iCpuWe, oData=iCpuData.
REQ-018 A CPU write (iCpuWe=1, iCpuAddr=DMA_REG_ADDR) SHALL load oDMA=iCpuData, clear the 8-bit index to 0, and enter READ (or DELAY).
REQ-019 Source high byte SHALL be oDMA when oDMA<8'hE0, else oDMA-8'h20 (echo folds onto work RAM); oDMA itself keeps the written value.
REQ-020 READ: oAddr={srcHigh,index}, oWe=0; next state LATCH.
REQ-021 LATCH: same oAddr, oWe=0; iMemData captured into an 8-bit holding register at the cycle's end; next state WRITE.
REQ-022 WRITE: oAddr=OAM_BASE+index, oWe=1, oData=holding register.
REQ-023 After WRITE: if index=DMA_LENGTH-1, go to IDLE and assert oDone for that WRITE cycle only; else increment index and go to READ.
REQ-024 oBusy SHALL be 1 in READ, LATCH and WRITE, and 0 in IDLE and DELAY.
REQ-025 A transfer therefore SHALL take exactly 3*DMA_LENGTH busy cycles (480 by default).
REQ-026 While busy, CPU writes other than to DMA_REG_ADDR SHALL NOT reach oWe.
REQ-027 A CPU write to DMA_REG_ADDR while busy or in DELAY SHALL restart the transfer: new oDMA, index=0, next state READ (or DELAY); no oDone from the aborted transfer.
REQ-028 Index arithmetic SHALL be 8-bit unsigned; the destination address SHALL be computed 16-bit without overflow into bits 15:8 for DMA_LENGTH<=256.

Reset
REQ-029 On iReset=1 at a rising edge: state=IDLE, index=0, holding register=0, oDMA=8'h00, oDone=0, oBusy=0.
REQ-030 Reset mid-transfer SHALL abort with no further DMA writes; passthrough resumes the next cycle.

Configuration
REQ-031 Macro OAM_DMA_START_DELAY_EN: when defined, a register write enters DELAY for one cycle (passthrough active, oBusy=0) before READ; when undefined, READ follows the register write directly.

Verification
REQ-032 Reset -> oBusy=0, oDone=0, oDMA=8'h00, oAddr tracks iCpuAddr.
REQ-033 Memory model C000..C09F = i^8'h5A, write FF46=8'hC0 at cycle T (macro off) -> oBusy high T+1..T+480, oDone only at T+480, FE00..FE9F = i^8'h5A.
REQ-034 Write FF46=8'hE1 -> reads from C100..C19F, oDMA reads back 8'hE1.
REQ-035 Write FF46=8'hC0, then FF46=8'hD0 at index 50 -> transfer restarts at index 0, OAM ends holding D000..D09F data, exactly one oDone.
REQ-036 iReset at index 80 -> oBusy=0 next cycle, no writes to FE50 or above.
REQ-037 CPU write 8'hAA to 8000 while busy -> not forwarded (oWe carries DMA activity only); with OAM_DMA_START_DELAY_EN defined, oBusy rises at T+2.
